store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 104 ++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores that drains to data memory one entry
// per cycle. Loads check it for forwarding, and the youngest matching store wins.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [AW-1:0]          DataAdr,
  input  logic [DW-1:0]          WriteData,
  input  logic [AW-1:0]          ReadAdr,
  output logic                   Stall,
  output logic                   FwdHit,
  output logic [DW-1:0]          FwdData,
  output logic                   MemReq,
  output logic [AW-1:0]          MemAdr,
  output logic [DW-1:0]          MemWData,
  input  logic                   MemReady,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] adr_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          full, enq, deq;
  logic [PW-1:0] fwd_idx;
  logic          unused_radr;

  // Word-granular forwarding ignores the byte offset.
  assign unused_radr = ^ReadAdr[1:0];

  assign full = (count_q == CW'(DEPTH));
  assign enq  = MemWrite && !full;
  assign deq  = (count_q != '0) && MemReady;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q || (MemWrite && full);
    if (enq) tail_d = tail_q + 1'b1;
    if (deq) head_d = head_q + 1'b1;
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage is never reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail_q] <= DataAdr;
      dat_q[tail_q] <= WriteData;
    end
  end

  // Scan oldest to youngest so that a later match overrides an earlier one.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (adr_q[fwd_idx][AW-1:2] == ReadAdr[AW-1:2])) begin
        FwdHit  = 1'b1;
        FwdData = dat_q[fwd_idx];
      end
    end
  end

  assign Stall    = full;
  assign MemReq   = (count_q != '0);
  assign MemAdr   = adr_q[head_q];
  assign MemWData = dat_q[head_q];
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based reference model and a negedge monitor, driven by
// directed scenarios followed by randomized traffic.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, ReadAdr;
  logic        Stall, FwdHit, MemReq, MemReady, Overflow;
  logic [31:0] FwdData, MemAdr, MemWData;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  ent_t exp_q[$];
  logic exp_ovf = 1'b0;
  logic popped  = 1'b0;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadAdr(ReadAdr), .Stall(Stall), .FwdHit(FwdHit),
    .FwdData(FwdData), .MemReq(MemReq), .MemAdr(MemAdr), .MemWData(MemWData),
    .MemReady(MemReady), .Count(Count), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted stores enter the queue; the monitor pops drained ones.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      popped  = 1'b0;
    end else if (clk) begin
      if (MemWrite) begin
        if (exp_q.size() + (popped ? 1 : 0) == DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back('{adr: DataAdr, dat: WriteData});
      end
      popped = 1'b0;
    end
  end

  // Monitor: compares all outputs mid-cycle and consumes entries as memory accepts them.
  always @(negedge clk) begin
    logic        hit;
    logic [31:0] fd;
    int          n;
    n   = exp_q.size();
    hit = 1'b0;
    fd  = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].adr[31:2] == ReadAdr[31:2]) begin
        hit = 1'b1;
        fd  = exp_q[i].dat;
      end
    end
    chk("mon_count", 64'(Count), 64'(n));
    chk("mon_stall", 64'(Stall), 64'(n == DEPTH));
    chk("mon_memreq", 64'(MemReq), 64'(n != 0));
    chk("mon_overflow", 64'(Overflow), 64'(exp_ovf));
    chk("mon_fwdhit", 64'(FwdHit), 64'(hit));
    chk("mon_fwddata", 64'(FwdData), 64'(fd));
    if (n > 0) begin
      chk("mon_memadr", 64'(MemAdr), 64'(exp_q[0].adr));
      chk("mon_memwdata", 64'(MemWData), 64'(exp_q[0].dat));
      if (MemReady && reset) begin
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic rdy, input logic [31:0] radr);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = dat;
    MemReady  = rdy;
    ReadAdr   = radr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b1, '0);
    for (int n = 0; n < 20 && Count != 0; n++) tick();
    chk("drain_done", 64'(Count), 64'd0);
  endtask

  initial begin
    drive(1'b1, 32'h50, 32'h55, 1'b0, 32'h50);
    reset = 1'b0;
    // Reset held with a store request pending: nothing may be enqueued.
    repeat (3) tick();
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_memreq", 64'(MemReq), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_overflow", 64'(Overflow), 64'd0);
    chk("rst_fwdhit", 64'(FwdHit), 64'd0);
    #2 reset = 1'b1;

    // Ordering and youngest-match forwarding.
    drive(1'b1, 32'h64, 32'd7, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h68, 32'd8, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h64, 32'd9, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h66); #1;
    chk("ord_count", 64'(Count), 64'd3);
    chk("ord_memadr", 64'(MemAdr), 64'h64);
    chk("ord_memwdata", 64'(MemWData), 64'd7);
    chk("fwd_hit_66", 64'(FwdHit), 64'd1);
    chk("fwd_data_66", 64'(FwdData), 64'd9);
    ReadAdr = 32'h6C; #1;
    chk("fwd_hit_6c", 64'(FwdHit), 64'd0);
    chk("fwd_data_6c", 64'(FwdData), 64'd0);
    tick(); tick();
    chk("ord_stable_adr", 64'(MemAdr), 64'h64);
    chk("ord_stable_dat", 64'(MemWData), 64'd7);
    drain();

    // Full buffer, dropped store, sticky overflow.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40 + 32'(4 * k), 32'(k + 1), 1'b0, 32'h0);
      tick();
    end
    chk("full_stall", 64'(Stall), 64'd1);
    drive(1'b1, 32'h80, 32'd5, 1'b0, 32'h80); tick();
    chk("ovf_set", 64'(Overflow), 64'd1);
    chk("ovf_count", 64'(Count), 64'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h80); #1;
    chk("ovf_no_fwd", 64'(FwdHit), 64'd0);
    for (int i = 0; i <= 4; i++) begin
      chk("drain_count", 64'(Count), 64'(4 - i));
      if (i < 4) chk("drain_adr", 64'(MemAdr), 64'(32'h40 + 32'(4 * i)));
      tick();
    end
    chk("ovf_sticky", 64'(Overflow), 64'd1);

    // Simultaneous enqueue/dequeue across pointer wrap.
    drive(1'b1, 32'h200, 32'hA0, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h204, 32'hA1, 1'b0, 32'h0); tick();
    for (int k = 2; k < 6; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k), 1'b1, 32'h0); #1;
      chk("sim_count", 64'(Count), 64'd2);
      chk("sim_head", 64'(MemWData), 64'(32'hA0 + 32'(k - 2)));
      tick();
    end
    chk("sim_count_end", 64'(Count), 64'd2);
    chk("wrap_head", 64'(MemAdr), 64'h210);
    drain();

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 32'(k), 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h300); #1;
    chk("mid_memreq_pre", 64'(MemReq), 64'd1);
    reset = 1'b0; #1;
    chk("mid_memreq", 64'(MemReq), 64'd0);
    chk("mid_count", 64'(Count), 64'd0);
    chk("mid_fwdhit", 64'(FwdHit), 64'd0);
    chk("mid_overflow", 64'(Overflow), 64'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    drive(1'b1, 32'h10, 32'd1, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0); #1;
    chk("post_memreq", 64'(MemReq), 64'd1);
    chk("post_memadr", 64'(MemAdr), 64'h10);
    drain();

    // Randomized traffic over a small address window to provoke hits and wraps.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)),
            32'h400 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
            $urandom, 1'($urandom_range(0, 99) < 40),
            32'h400 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)));
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
